// File: rtl/lb_reg_pkg.sv
// lb_reg_pkg
// Shared constants and types for the local-bus register responder.
//   - Window offsets of the status block, uptime counter, ID word and the
//     optional miss counter (LB_MISS_COUNT_EN builds only).
//   - Default ID word returned at OFF_ID.
//   - Access classification used by the decoder.
package lb_reg_pkg;

    localparam logic [4:0]  OFF_STATUS      = 5'h10;
    localparam logic [4:0]  OFF_UPTIME      = 5'h18;
    localparam logic [4:0]  OFF_ID          = 5'h19;
    localparam logic [4:0]  OFF_MISS        = 5'h1A;
    localparam logic [31:0] DEFAULT_ID_WORD = 32'h6c627270;
    localparam int          NUM_STATUS      = 8;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_READ,
        ACC_WRITE
    } accessKind_e;

    // Status words occupy offsets 0x10..0x17, so bits [2:0] select the word.
    function automatic logic isStatusOffset(input logic [4:0] off);
        return (off >= OFF_STATUS) && (off < OFF_UPTIME);
    endfunction

endpackage

// File: rtl/lb_reg_responder_rd_pipe.sv
// lb_rd_pipe
// Fixed-latency valid/data shift pipeline for local-bus read returns.
// A word entering on valid_i appears on valid_o/data_o exactly DEPTH cycles
// later. Each data stage only loads when its incoming valid is set, so the
// final stage (data_o) holds the last returned word between reads.
// Ports:
//   clk      in   pipeline clock
//   rst      in   synchronous active-high reset, clears valids and data
//   valid_i  in   launch a read this cycle
//   data_i   in   word captured for the launched read
//   valid_o  out  one-cycle pulse per launched read, DEPTH cycles later
//   data_o   out  returned word, held until the next valid
module lb_rd_pipe #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    // Stage k is fed by entry k of these extended vectors: entry 0 is the
    // pipeline input, entry k+1 is stage k. Avoids special-casing DEPTH=1.
    logic [DEPTH:0]   validFeed;
    logic [WIDTH-1:0] dataFeed [DEPTH+1];

    always_comb begin
        validFeed[0] = valid_i;
        dataFeed[0]  = data_i;
        for (int k = 0; k < DEPTH; k++) begin
            validFeed[k+1] = valid_q[k];
            dataFeed[k+1]  = data_q[k];
        end
    end

    // Shift valids every cycle; data stages only load alongside a valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                valid_q[k] <= validFeed[k];
                if (validFeed[k]) begin
                    data_q[k] <= dataFeed[k];
                end
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/lb_reg_responder.sv
// lb_reg_responder
// Local-bus slave decoding a 32-word window at BASE:
//   0x00..NREG-1  RW control registers (reg_out, wr_pulse on write)
//   0x10..0x17    RO status words from status_in
//   0x18          free-running uptime counter, write clears
//   0x19          ID_WORD
//   0x1A          miss counter, write clears (only with LB_MISS_COUNT_EN)
// Reads return through a READ_DELAY-stage pipeline; everything else reads 0.
// Optional feature macro: LB_MISS_COUNT_EN (16-bit saturating count of
// in-window accesses to unmapped offsets).
// Ports:
//   lb_clk       in   sole clock
//   rst          in   synchronous active-high reset
//   lb_addr      in   24-bit word address
//   lb_strobe    in   access qualifier
//   lb_rd        in   read request (ignored when lb_write is also high)
//   lb_write     in   write request
//   lb_data_out  in   write data from master
//   lb_data_in   out  read data to master, held between reads
//   rd_valid     out  one-cycle pulse when lb_data_in carries a new word
//   status_in    in   8 x 32-bit status words, word k at [32k+31:32k]
//   reg_out      out  NREG x 32-bit control registers, same packing
//   wr_pulse     out  per-register one-cycle write pulse
module lb_reg_responder
    import lb_reg_pkg::*;
#(
    parameter logic [23:0] BASE       = 24'h000000,
    parameter int          NREG       = 8,
    parameter int          READ_DELAY = 3,
    parameter logic [31:0] ID_WORD    = DEFAULT_ID_WORD
) (
    input  logic                     lb_clk,
    input  logic                     rst,
    input  logic [23:0]              lb_addr,
    input  logic                     lb_strobe,
    input  logic                     lb_rd,
    input  logic                     lb_write,
    input  logic [31:0]              lb_data_out,
    output logic [31:0]              lb_data_in,
    output logic                     rd_valid,
    input  logic [32*NUM_STATUS-1:0] status_in,
    output logic [NREG*32-1:0]       reg_out,
    output logic [NREG-1:0]          wr_pulse
);

    logic [4:0]  offset;
    accessKind_e accessKind;
    logic        isWrite;
    logic [31:0] readWord;

    logic [31:0]     ctrlRegs_q [NREG];
    logic [31:0]     ctrlRegs_d [NREG];
    logic [NREG-1:0] wrPulse_q;
    logic [NREG-1:0] wrPulse_d;
    logic [31:0]     uptime_q;
    logic [31:0]     uptime_d;

`ifdef LB_MISS_COUNT_EN
    logic [15:0] missCount_q;
    logic [15:0] missCount_d;
    logic        offsetMapped;
`endif

    // Decode: a cycle with both lb_rd and lb_write is treated as a write only.
    always_comb begin
        offset     = lb_addr[4:0];
        accessKind = ACC_NONE;
        if (lb_strobe && (lb_addr[23:5] == BASE[23:5])) begin
            if (lb_write) begin
                accessKind = ACC_WRITE;
            end else if (lb_rd) begin
                accessKind = ACC_READ;
            end
        end
        isWrite = (accessKind == ACC_WRITE);
    end

    // Read mux samples pre-write register values, so a read always returns
    // the state seen at the strobe edge.
    always_comb begin
        readWord = 32'h0;
        for (int k = 0; k < NREG; k++) begin
            if (offset == 5'(k)) begin
                readWord = ctrlRegs_q[k];
            end
        end
        if (isStatusOffset(offset)) begin
            readWord = status_in[{offset[2:0], 5'b00000} +: 32];
        end
        if (offset == OFF_UPTIME) begin
            readWord = uptime_q;
        end
        if (offset == OFF_ID) begin
            readWord = ID_WORD;
        end
`ifdef LB_MISS_COUNT_EN
        if (offset == OFF_MISS) begin
            readWord = {16'h0, missCount_q};
        end
`endif
    end

    // Control register writes and their one-cycle pulses.
    always_comb begin
        wrPulse_d = '0;
        for (int k = 0; k < NREG; k++) begin
            ctrlRegs_d[k] = ctrlRegs_q[k];
            if (isWrite && (offset == 5'(k))) begin
                ctrlRegs_d[k] = lb_data_out;
                wrPulse_d[k]  = 1'b1;
            end
        end
    end

    // Uptime: a clear-write wins over the increment.
    always_comb begin
        uptime_d = uptime_q + 32'd1;
        if (isWrite && (offset == OFF_UPTIME)) begin
            uptime_d = 32'h0;
        end
    end

    always_ff @(posedge lb_clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                ctrlRegs_q[k] <= '0;
            end
            wrPulse_q <= '0;
            uptime_q  <= '0;
        end else begin
            for (int k = 0; k < NREG; k++) begin
                ctrlRegs_q[k] <= ctrlRegs_d[k];
            end
            wrPulse_q <= wrPulse_d;
            uptime_q  <= uptime_d;
        end
    end

`ifdef LB_MISS_COUNT_EN
    // Miss counter: counts in-window reads/writes to offsets with nothing
    // behind them; writes to RO status/ID are mapped and not counted.
    always_comb begin
        offsetMapped = isStatusOffset(offset) || (offset == OFF_UPTIME) ||
                       (offset == OFF_ID) || (offset == OFF_MISS);
        for (int k = 0; k < NREG; k++) begin
            if (offset == 5'(k)) begin
                offsetMapped = 1'b1;
            end
        end
        missCount_d = missCount_q;
        if (isWrite && (offset == OFF_MISS)) begin
            missCount_d = 16'h0;
        end else if ((accessKind != ACC_NONE) && !offsetMapped &&
                     (missCount_q != 16'hFFFF)) begin
            missCount_d = missCount_q + 16'd1;
        end
    end

    always_ff @(posedge lb_clk) begin
        if (rst) begin
            missCount_q <= '0;
        end else begin
            missCount_q <= missCount_d;
        end
    end
`endif

    lb_rd_pipe #(
        .DEPTH (READ_DELAY),
        .WIDTH (32)
    ) rdPipe (
        .clk     (lb_clk),
        .rst     (rst),
        .valid_i (accessKind == ACC_READ),
        .data_i  (readWord),
        .valid_o (rd_valid),
        .data_o  (lb_data_in)
    );

    for (genvar g = 0; g < NREG; g++) begin : gPack
        assign reg_out[32*g +: 32] = ctrlRegs_q[g];
    end

    assign wr_pulse = wrPulse_q;

endmodule

// File: tb/tb_lb_reg_responder.sv
// tb_lb_reg_responder
// Directed bench for lb_reg_responder: register write/read-back, status/ID
// reads back-to-back, reset discarding an in-flight read, uptime clear at
// the wrap point, out-of-window accesses and the optional miss counter
// (LB_MISS_COUNT_EN).
module tb_lb_reg_responder;

    localparam logic [23:0] BASE       = 24'h012340;
    localparam logic [23:0] OUTSIDE    = BASE ^ 24'h000020;
    localparam int          NREG       = 8;
    localparam int          READ_DELAY = 3;
    localparam logic [31:0] ID_WORD    = 32'h6c627270;

    logic                 lb_clk;
    logic                 rst;
    logic [23:0]          lb_addr;
    logic                 lb_strobe;
    logic                 lb_rd;
    logic                 lb_write;
    logic [31:0]          lb_data_out;
    logic [31:0]          lb_data_in;
    logic                 rd_valid;
    logic [255:0]         status_in;
    logic [NREG*32-1:0]   reg_out;
    logic [NREG-1:0]      wr_pulse;

    int checkCount = 0;
    int passCount  = 0;
    int validCount = 0;
    int countMark;
    logic [31:0] lastRead;

    lb_reg_responder #(
        .BASE       (BASE),
        .NREG       (NREG),
        .READ_DELAY (READ_DELAY),
        .ID_WORD    (ID_WORD)
    ) dut (
        .lb_clk      (lb_clk),
        .rst         (rst),
        .lb_addr     (lb_addr),
        .lb_strobe   (lb_strobe),
        .lb_rd       (lb_rd),
        .lb_write    (lb_write),
        .lb_data_out (lb_data_out),
        .lb_data_in  (lb_data_in),
        .rd_valid    (rd_valid),
        .status_in   (status_in),
        .reg_out     (reg_out),
        .wr_pulse    (wr_pulse)
    );

    initial lb_clk = 1'b0;
    always #5 lb_clk = ~lb_clk;

    // Count rd_valid pulses shortly after each rising edge.
    always begin
        @(posedge lb_clk);
        #1;
        if (rd_valid) validCount++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [23:0] addr, input logic [31:0] data);
        @(negedge lb_clk);
        lb_strobe   = 1'b1;
        lb_rd       = rd;
        lb_write    = wr;
        lb_addr     = addr;
        lb_data_out = data;
    endtask

    task automatic idleCycle();
        @(negedge lb_clk);
        lb_strobe = 1'b0;
        lb_rd     = 1'b0;
        lb_write  = 1'b0;
    endtask

    // Waits for the read launched at the previous negedge and checks both
    // its latency and the returned word.
    task automatic expectRead(input string tag, input logic [31:0] expData);
        int lat;
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            idleCycle();
            if (rd_valid) begin
                lat = n;
                break;
            end
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(READ_DELAY));
        checkOutput({tag, "_data"}, lb_data_in, expData);
    endtask

    task automatic readReg(input string tag, input logic [23:0] addr,
                           input logic [31:0] expData);
        applyStimulus(1'b1, 1'b0, addr, 32'h0);
        expectRead(tag, expData);
    endtask

    initial begin
        rst         = 1'b1;
        lb_strobe   = 1'b0;
        lb_rd       = 1'b0;
        lb_write    = 1'b0;
        lb_addr     = 24'h0;
        lb_data_out = 32'h0;
        for (int k = 0; k < 8; k++) begin
            status_in[32*k +: 32] = 32'hA5A5_0001 + 32'(k) * 32'h100;
        end

        // Reset state
        repeat (3) @(negedge lb_clk);
        checkOutput("reset_rd_valid", {31'b0, rd_valid}, 32'h0);
        checkOutput("reset_data", lb_data_in, 32'h0);
        checkOutput("reset_wr_pulse", 32'(wr_pulse), 32'h0);
        checkOutput("reset_reg2", reg_out[64 +: 32], 32'h0);
        rst = 1'b0;

        // Register write, single-cycle pulse, read-back with fixed latency
        applyStimulus(1'b0, 1'b1, BASE + 24'd2, 32'h1234_5678);
        idleCycle();
        checkOutput("wr_pulse_reg2", 32'(wr_pulse), 32'h0000_0004);
        checkOutput("reg_out_reg2", reg_out[64 +: 32], 32'h1234_5678);
        idleCycle();
        checkOutput("wr_pulse_clear", 32'(wr_pulse), 32'h0);
        readReg("rd_reg2", BASE + 24'd2, 32'h1234_5678);
        lastRead = 32'h1234_5678;
        idleCycle();
        idleCycle();
        checkOutput("data_hold", lb_data_in, lastRead);
        checkOutput("valid_single", {31'b0, rd_valid}, 32'h0);

        // rd and write together: write happens, no read launched
        countMark = validCount;
        applyStimulus(1'b1, 1'b1, BASE + 24'd3, 32'hCAFE_F00D);
        repeat (6) idleCycle();
        checkOutput("rdwr_no_valid", 32'(validCount - countMark), 32'h0);
        checkOutput("rdwr_reg3", reg_out[96 +: 32], 32'hCAFE_F00D);

        // Back-to-back reads: ID, status word 0, unmapped 0x0F
        applyStimulus(1'b1, 1'b0, BASE + 24'h19, 32'h0);
        applyStimulus(1'b1, 1'b0, BASE + 24'h10, 32'h0);
        applyStimulus(1'b1, 1'b0, BASE + 24'h0F, 32'h0);
        idleCycle();
        checkOutput("b2b_valid0", {31'b0, rd_valid}, 32'h1);
        checkOutput("b2b_id", lb_data_in, 32'h6c62_7270);
        idleCycle();
        checkOutput("b2b_valid1", {31'b0, rd_valid}, 32'h1);
        checkOutput("b2b_status0", lb_data_in, 32'hA5A5_0001);
        idleCycle();
        checkOutput("b2b_valid2", {31'b0, rd_valid}, 32'h1);
        checkOutput("b2b_unmapped", lb_data_in, 32'h0);
        idleCycle();
        checkOutput("b2b_end", {31'b0, rd_valid}, 32'h0);

        // Window edges
        readReg("rd_status7", BASE + 24'h17, 32'hA5A5_0701);
        readReg("rd_nreg", BASE + 24'h08, 32'h0);
        readReg("rd_1b", BASE + 24'h1B, 32'h0);
`ifndef LB_MISS_COUNT_EN
        readReg("rd_1a_off", BASE + 24'h1A, 32'h0);
`endif
        readReg("rd_reg3", BASE + 24'd3, 32'hCAFE_F00D);
        lastRead = 32'hCAFE_F00D;

        // Out-of-window write and read
        applyStimulus(1'b0, 1'b1, BASE + 24'd1, 32'h1111_1111);
        idleCycle();
        applyStimulus(1'b0, 1'b1, OUTSIDE + 24'd1, 32'hDEAD_BEEF);
        idleCycle();
        checkOutput("outside_wr_pulse", 32'(wr_pulse), 32'h0);
        checkOutput("outside_reg1", reg_out[32 +: 32], 32'h1111_1111);
        countMark = validCount;
        applyStimulus(1'b1, 1'b0, OUTSIDE + 24'd1, 32'h0);
        repeat (6) idleCycle();
        checkOutput("outside_no_valid", 32'(validCount - countMark), 32'h0);
        checkOutput("outside_data_hold", lb_data_in, lastRead);

        // Reset one cycle after a read strobe discards the read
        applyStimulus(1'b1, 1'b0, BASE + 24'd2, 32'h0);
        @(negedge lb_clk);
        lb_strobe = 1'b0;
        lb_rd     = 1'b0;
        rst       = 1'b1;
        @(negedge lb_clk);
        rst = 1'b0;
        checkOutput("rst_reg2", reg_out[64 +: 32], 32'h0);
        checkOutput("rst_reg3", reg_out[96 +: 32], 32'h0);
        checkOutput("rst_data", lb_data_in, 32'h0);
        readReg("rst_uptime", BASE + 24'h18, 32'h1);

        // Uptime clear, then count from zero
        applyStimulus(1'b0, 1'b1, BASE + 24'h18, 32'h0);
        repeat (4) idleCycle();
        readReg("uptime_after_clear", BASE + 24'h18, 32'h4);

        // Clear on the wrap cycle
        applyStimulus(1'b1, 1'b0, BASE + 24'h18, 32'h0);
        force dut.uptime_q = 32'hFFFF_FFFF;
        applyStimulus(1'b0, 1'b1, BASE + 24'h18, 32'h0);
        release dut.uptime_q;
        applyStimulus(1'b1, 1'b0, BASE + 24'h18, 32'h0);
        idleCycle();
        checkOutput("wrap_valid0", {31'b0, rd_valid}, 32'h1);
        checkOutput("wrap_max", lb_data_in, 32'hFFFF_FFFF);
        idleCycle();
        checkOutput("wrap_gap", {31'b0, rd_valid}, 32'h0);
        idleCycle();
        checkOutput("wrap_valid1", {31'b0, rd_valid}, 32'h1);
        checkOutput("wrap_cleared", lb_data_in, 32'h0);

`ifdef LB_MISS_COUNT_EN
        // Miss counter: three unmapped accesses, read, clear, read
        applyStimulus(1'b0, 1'b1, BASE + 24'h1A, 32'h0);
        applyStimulus(1'b1, 1'b0, BASE + 24'h1F, 32'h0);
        applyStimulus(1'b0, 1'b1, BASE + 24'h1F, 32'h5555_5555);
        applyStimulus(1'b1, 1'b0, BASE + 24'h1F, 32'h0);
        repeat (4) idleCycle();
        readReg("miss_count3", BASE + 24'h1A, 32'h3);
        applyStimulus(1'b0, 1'b1, BASE + 24'h1A, 32'h0);
        idleCycle();
        readReg("miss_cleared", BASE + 24'h1A, 32'h0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
